// File: rtl/lego_fetch_decode_if.sv
// Fetch/decode bundle: PC and instruction-memory handshake in, decoded fields out.
// master = fetch/decode unit, slave = PC counter / memory / consumer side.
interface lego_fetch_decode_if;
   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OPC_W   = 11;
   localparam int unsigned REG_W   = 5;

   logic [ADDR_W-1:0]  pc;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic               stall;
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               instr_valid;
   logic               pc_step;
   logic [OPC_W-1:0]   opcode;
   logic [REG_W-1:0]   rd;
   logic [REG_W-1:0]   rn;
   logic [REG_W-1:0]   rm;
   logic [ADDR_W-1:0]  extended_and_shifted;
   logic               fetch_err;

   modport master (
      input  pc, imem_ack, imem_rdata, stall,
      output imem_req, imem_addr, instr_valid, pc_step, opcode, rd, rn, rm,
             extended_and_shifted, fetch_err
   );

   modport slave (
      output pc, imem_ack, imem_rdata, stall,
      input  imem_req, imem_addr, instr_valid, pc_step, opcode, rd, rn, rm,
             extended_and_shifted, fetch_err
   );
endinterface

// File: rtl/lego_fetch_decode.sv
// LEGv8 instruction fetch + decode front end (IDLE/REQ/EXEC/ERR).
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module lego_fetch_decode #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic                 clk,
   input logic                 rst,
   lego_fetch_decode_if.master bus
);
   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OPC_W   = 11;
   localparam int unsigned REG_W   = 5;

   typedef enum logic [1:0] {IDLE, REQ, EXEC, ERR} state_e;

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               req_q, valid_q;
   logic [OPC_W-1:0]   opcode_q, opcode_d;
   logic [REG_W-1:0]   rd_q, rn_q, rm_q, rd_d, rn_d, rm_d;
   logic [ADDR_W-1:0]  imm_q, imm_d;
   logic               pc_step_c;
   logic               timeout_c;

   // Next-state and IR/address capture
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      addr_d    = addr_q;
      pc_step_c = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = REQ;
            addr_d  = bus.pc;
         end
         REQ: begin
            if (bus.imem_ack) begin
               ir_d    = bus.imem_rdata;
               state_d = EXEC;
            end else if (timeout_c) begin
               state_d = ERR;
               addr_d  = '0;
            end
         end
         EXEC: begin
            if (!bus.stall) begin
               pc_step_c = 1'b1;
               state_d   = REQ;
               addr_d    = bus.pc + ADDR_W'(1);
            end
         end
         ERR: begin
            addr_d = '0;
         end
      endcase
   end

   // Decode from the IR value that will be held after this edge
   always_comb begin
      logic b_fmt, cb_fmt;
      b_fmt    = (ir_d[31:26] == 6'b000101);
      cb_fmt   = (ir_d[31:24] == 8'hB4) || (ir_d[31:24] == 8'hB5);
      opcode_d = '0;
      imm_d    = '0;
      rd_d     = '0;
      rn_d     = '0;
      rm_d     = '0;
      if (state_d == EXEC) begin
         if (b_fmt)       opcode_d = 11'h0A0;
         else if (cb_fmt) opcode_d = {ir_d[31:24], 3'b000};
         else             opcode_d = ir_d[31:21];
         if (b_fmt)
            imm_d = {{38{ir_d[25]}}, ir_d[25:0]};
         else if (cb_fmt)
            imm_d = {{45{ir_d[23]}}, ir_d[23:5]};
         else if (opcode_d == 11'h7C0 || opcode_d == 11'h7C2)
            imm_d = {{55{ir_d[20]}}, ir_d[20:12]};
         else if (ir_d[31:22] == 10'h244 || ir_d[31:22] == 10'h344)
            imm_d = {52'd0, ir_d[21:10]};
         rd_d = ir_d[4:0];
         rn_d = ir_d[9:5];
         rm_d = ir_d[20:16];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ir_q     <= '0;
         addr_q   <= '0;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         opcode_q <= '0;
         rd_q     <= '0;
         rn_q     <= '0;
         rm_q     <= '0;
         imm_q    <= '0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         addr_q   <= addr_d;
         req_q    <= (state_d == REQ);
         valid_q  <= (state_d == EXEC);
         opcode_q <= opcode_d;
         rd_q     <= rd_d;
         rn_q     <= rn_d;
         rm_q     <= rm_d;
         imm_q    <= imm_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q;

   // Count REQ cycles without ack; cleared on REQ entry
   always_comb begin
      cnt_d = cnt_q;
      if (state_d == REQ)
         cnt_d = (state_q == REQ) ? cnt_q + CNT_W'(1) : '0;
   end

   assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= (state_d == ERR);
      end
   end

   assign bus.fetch_err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout_c      = 1'b0;
   assign bus.fetch_err  = 1'b0;
`endif

   assign bus.imem_req             = req_q;
   assign bus.imem_addr            = addr_q;
   assign bus.instr_valid          = valid_q;
   assign bus.pc_step              = pc_step_c;
   assign bus.opcode               = opcode_q;
   assign bus.rd                   = rd_q;
   assign bus.rn                   = rn_q;
   assign bus.rm                   = rm_q;
   assign bus.extended_and_shifted = imm_q;
endmodule

// File: tb/tb_lego_fetch_decode.sv
// Directed self-checking bench for lego_fetch_decode (TIMEOUT_CYCLES=4).
module tb_lego_fetch_decode;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   lego_fetch_decode_if bus ();

   lego_fetch_decode #(.TIMEOUT_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.pc = '0; bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.stall = 1'b0;
      #2 rst = 1'b1;
      step(); step();
      n_checks++;
      if ({bus.imem_req, bus.instr_valid, bus.pc_step, bus.opcode, bus.rd, bus.rn, bus.rm,
           bus.extended_and_shifted, bus.imem_addr, bus.fetch_err} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: req=%0b valid=%0b addr=%0h want all zero",
                            bus.imem_req, bus.instr_valid, bus.imem_addr);
      end
      rst = 1'b0; bus.pc = 64'd9;
      step();
      n_checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 64'd9}) begin
         n_fail++; $display("FAIL first_req: req=%0b addr=%0h want 1/9", bus.imem_req, bus.imem_addr);
      end
      // Asynchronous reset in the middle of REQ
      rst = 1'b1; #1;
      n_checks++;
      if (bus.imem_req !== 1'b0) begin
         n_fail++; $display("FAIL rst_async_req: got %0b want 0", bus.imem_req);
      end
      step();
      rst = 1'b0; bus.pc = '0;
      step();
      n_checks++;
      if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 64'd0, 1'b0}) begin
         n_fail++; $display("FAIL release_req: req=%0b addr=%0h valid=%0b want 1/0/0",
                            bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
   endtask

   task automatic test_b_decode();
      bus.imem_rdata = 32'h17FFFFFE; bus.imem_ack = 1'b1;
      step();
      bus.imem_ack = 1'b0;
      n_checks++;
      if ({bus.instr_valid, bus.opcode, bus.extended_and_shifted, bus.pc_step, bus.imem_req}
          !== {1'b1, 11'h0A0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL b_decode: valid=%0b opc=%0h imm=%0h step=%0b want 1/0a0/fffffffffffffffe/1",
                            bus.instr_valid, bus.opcode, bus.extended_and_shifted, bus.pc_step);
      end
      step();
      bus.pc = 64'd1;
      n_checks++;
      if ({bus.pc_step, bus.instr_valid, bus.opcode, bus.imem_req, bus.imem_addr}
          !== {1'b0, 1'b0, 11'h000, 1'b1, 64'd1}) begin
         n_fail++; $display("FAIL b_next_req: step=%0b valid=%0b opc=%0h req=%0b addr=%0h want 0/0/0/1/1",
                            bus.pc_step, bus.instr_valid, bus.opcode, bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_cbz_stall();
      bus.imem_rdata = 32'hB4000143; bus.imem_ack = 1'b1; bus.stall = 1'b1;
      step();
      bus.imem_ack = 1'b0; bus.imem_rdata = 32'hDEADBEEF;
      n_checks++;
      if ({bus.opcode, bus.extended_and_shifted, bus.rd, bus.rn, bus.rm}
          !== {11'h5A0, 64'd10, 5'd3, 5'd10, 5'd0}) begin
         n_fail++; $display("FAIL cbz_decode: opc=%0h imm=%0h rd=%0d rn=%0d rm=%0d want 5a0/a/3/10/0",
                            bus.opcode, bus.extended_and_shifted, bus.rd, bus.rn, bus.rm);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if ({bus.instr_valid, bus.pc_step, bus.imem_req, bus.opcode, bus.extended_and_shifted, bus.rd}
             !== {1'b1, 1'b0, 1'b0, 11'h5A0, 64'd10, 5'd3}) begin
            n_fail++; $display("FAIL stall_hold[%0d]: valid=%0b step=%0b opc=%0h imm=%0h want 1/0/5a0/a",
                               i, bus.instr_valid, bus.pc_step, bus.opcode, bus.extended_and_shifted);
         end
      end
      bus.stall = 1'b0; #1;
      n_checks++;
      if (bus.pc_step !== 1'b1) begin
         n_fail++; $display("FAIL stall_release_step: got %0b want 1", bus.pc_step);
      end
      step();
      bus.pc = 64'd2;
      n_checks++;
      if ({bus.pc_step, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 64'd2}) begin
         n_fail++; $display("FAIL stall_next_req: step=%0b req=%0b addr=%0h want 0/1/2",
                            bus.pc_step, bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] ldur;
      ldur = {11'h7C2, 9'h1FD, 2'b00, 5'd2, 5'd1};
      for (int i = 0; i < 3; i++) begin
         bus.imem_rdata = 32'h8B000000 + 32'(i);
         step();
         n_checks++;
         if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 64'd2, 1'b0}) begin
            n_fail++; $display("FAIL wait_req[%0d]: req=%0b addr=%0h valid=%0b want 1/2/0",
                               i, bus.imem_req, bus.imem_addr, bus.instr_valid);
         end
      end
      bus.imem_rdata = ldur; bus.imem_ack = 1'b1; bus.stall = 1'b1;
      step();
      n_checks++;
      if ({bus.instr_valid, bus.opcode, bus.extended_and_shifted, bus.rn, bus.rd}
          !== {1'b1, 11'h7C2, 64'hFFFF_FFFF_FFFF_FFFD, 5'd2, 5'd1}) begin
         n_fail++; $display("FAIL ldur_decode: valid=%0b opc=%0h imm=%0h rn=%0d rd=%0d want 1/7c2/fffffffffffffffd/2/1",
                            bus.instr_valid, bus.opcode, bus.extended_and_shifted, bus.rn, bus.rd);
      end
      // Late ack while in EXEC must be ignored
      bus.imem_rdata = 32'hB4000143;
      step();
      bus.imem_ack = 1'b0;
      n_checks++;
      if ({bus.opcode, bus.extended_and_shifted, bus.imem_req} !== {11'h7C2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0}) begin
         n_fail++; $display("FAIL late_ack_ignored: opc=%0h imm=%0h req=%0b want 7c2/fffffffffffffffd/0",
                            bus.opcode, bus.extended_and_shifted, bus.imem_req);
      end
      bus.stall = 1'b0;
      step();
      bus.pc = 64'd3;
      n_checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 64'd3}) begin
         n_fail++; $display("FAIL wait_next_req: req=%0b addr=%0h want 1/3", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_back_to_back();
      bus.imem_rdata = 32'h913FFC41; bus.imem_ack = 1'b1;
      step();
      n_checks++;
      if ({bus.instr_valid, bus.pc_step, bus.opcode, bus.extended_and_shifted, bus.rn, bus.rd}
          !== {1'b1, 1'b1, 11'h489, 64'h0000_0000_0000_0FFF, 5'd2, 5'd1}) begin
         n_fail++; $display("FAIL addi_decode: valid=%0b step=%0b opc=%0h imm=%0h want 1/1/489/fff",
                            bus.instr_valid, bus.pc_step, bus.opcode, bus.extended_and_shifted);
      end
      step();
      bus.pc = 64'd4; bus.imem_rdata = 32'h8B030041;
      n_checks++;
      if ({bus.imem_req, bus.imem_addr, bus.pc_step} !== {1'b1, 64'd4, 1'b0}) begin
         n_fail++; $display("FAIL b2b_req: req=%0b addr=%0h step=%0b want 1/4/0",
                            bus.imem_req, bus.imem_addr, bus.pc_step);
      end
      step();
      bus.imem_ack = 1'b0;
      n_checks++;
      if ({bus.instr_valid, bus.opcode, bus.extended_and_shifted, bus.rm, bus.rn, bus.rd}
          !== {1'b1, 11'h458, 64'd0, 5'd3, 5'd2, 5'd1}) begin
         n_fail++; $display("FAIL add_decode: valid=%0b opc=%0h imm=%0h rm=%0d want 1/458/0/3",
                            bus.instr_valid, bus.opcode, bus.extended_and_shifted, bus.rm);
      end
      step();
      bus.pc = 64'd5;
      n_checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 64'd5}) begin
         n_fail++; $display("FAIL b2b_tail_req: req=%0b addr=%0h want 1/5", bus.imem_req, bus.imem_addr);
      end
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      for (int i = 0; i < 3; i++) step();
      n_checks++;
      if ({bus.imem_req, bus.fetch_err} !== 2'b10) begin
         n_fail++; $display("FAIL timeout_pre: req=%0b err=%0b want 1/0", bus.imem_req, bus.fetch_err);
      end
      step();
      n_checks++;
      if ({bus.fetch_err, bus.imem_req, bus.instr_valid, bus.imem_addr} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
         n_fail++; $display("FAIL timeout_err: err=%0b req=%0b addr=%0h want 1/0/0",
                            bus.fetch_err, bus.imem_req, bus.imem_addr);
      end
      bus.imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) step();
      bus.imem_ack = 1'b0;
      n_checks++;
      if ({bus.fetch_err, bus.instr_valid} !== 2'b10) begin
         n_fail++; $display("FAIL timeout_sticky: err=%0b valid=%0b want 1/0", bus.fetch_err, bus.instr_valid);
      end
      rst = 1'b1; #1;
      n_checks++;
      if (bus.fetch_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_rst: err=%0b want 0", bus.fetch_err);
      end
      step();
      rst = 1'b0; bus.pc = 64'd7;
      step();
      for (int i = 0; i < 3; i++) step();
      bus.imem_rdata = 32'h17FFFFFE; bus.imem_ack = 1'b1; bus.stall = 1'b1;
      step();
      bus.imem_ack = 1'b0;
      n_checks++;
      if ({bus.fetch_err, bus.instr_valid, bus.opcode} !== {1'b0, 1'b1, 11'h0A0}) begin
         n_fail++; $display("FAIL timeout_ack_wins: err=%0b valid=%0b opc=%0h want 0/1/0a0",
                            bus.fetch_err, bus.instr_valid, bus.opcode);
      end
      bus.stall = 1'b0;
   endtask
`else
   task automatic test_timeout();
      for (int i = 0; i < 6; i++) step();
      n_checks++;
      if ({bus.imem_req, bus.fetch_err, bus.imem_addr} !== {1'b1, 1'b0, 64'd5}) begin
         n_fail++; $display("FAIL no_timeout_wait: req=%0b err=%0b addr=%0h want 1/0/5",
                            bus.imem_req, bus.fetch_err, bus.imem_addr);
      end
      bus.imem_rdata = 32'h17FFFFFE; bus.imem_ack = 1'b1; bus.stall = 1'b1;
      step();
      bus.imem_ack = 1'b0;
      n_checks++;
      if ({bus.fetch_err, bus.instr_valid, bus.opcode} !== {1'b0, 1'b1, 11'h0A0}) begin
         n_fail++; $display("FAIL no_timeout_ack: err=%0b valid=%0b opc=%0h want 0/1/0a0",
                            bus.fetch_err, bus.instr_valid, bus.opcode);
      end
      bus.stall = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_b_decode();
      test_cbz_stall();
      test_wait_states();
      test_back_to_back();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
